uart_cmd_responder: RTL and testbench
=====================================

Name: uart_cmd_responder

Overview:
- Host-facing end of the debug UART link: parses framed command bytes from the uart_rx output and executes 32-bit memory-mapped reads/writes on the CPU data bus.
- Replies through the uart_tx input handshake with ACK/NAK and read data.
- Sits in top between urx/utx and the riscv_multi memory-mapped I/O port. Lets a host poke toggle_value or load memory without resynthesis.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 2_000_000, max idle clk cycles between bytes inside a frame before abort (about 167 ms at 12 MHz).
- MEM_TIMEOUT_CYCLES, 1024, max cycles waiting for mem_ready.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- rx_dv  in  1  one-cycle strobe, rx_byte valid (from uart_rx o_Rx_DV)
- rx_byte  in  8  received byte
- tx_dv  out  1  one-cycle strobe, start sending tx_byte (to uart_tx i_Tx_DV)
- tx_byte  out  8  byte to send; stable from the tx_dv cycle until tx_done
- tx_active  in  1  uart_tx busy
- tx_done  in  1  uart_tx one-cycle completion strobe
- mem_addr  out  32  bus address
- mem_wdata  out  32  write data
- mem_we  out  1  write request, held until mem_ready
- mem_re  out  1  read request, held until mem_ready
- mem_rdata  in  32  read data, valid when mem_ready=1
- mem_ready  in  1  bus completes the request in this cycle
- busy  out  1  high in every state except IDLE
- err_count  out  8  saturating count of NAK/timeout/overrun events

Behaviour:
- Reset (async, resetn=0): state IDLE. tx_dv=0, tx_byte=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, busy=0, err_count=0. Reset mid-frame or mid-transmission discards everything; no further tx_dv is issued.
- Frame format: SYNC, CMD, ADDR[4] (LSB first), DATA[4] (LSB first, write only), CSUM. CSUM is the XOR of all bytes after SYNC. CMD 8'h57 'W' = write; CMD 8'h52 'R' = read.
- States and transitions:
  - IDLE: on rx_dv with rx_byte==SYNC_BYTE -> CMD. Other bytes are ignored with no count.
  - CMD: a W/R byte -> ADDR. Any other value -> RESP with NAK 8'h15, err_count+1.
  - ADDR: collects 4 bytes with a 2-bit index, wrapping 3->0. -> DATA for W, CSUM for R.
  - DATA: collects 4 bytes -> CSUM.
  - CSUM: match -> EXEC. Mismatch -> RESP with NAK, err_count+1, no bus access.
  - EXEC: asserts mem_we or mem_re the cycle after CSUM, holding mem_addr/mem_wdata stable. On the mem_ready cycle it deasserts the request and captures mem_rdata. If mem_ready is absent for MEM_TIMEOUT_CYCLES -> NAK, err_count+1.
  - RESP: write sends ACK 8'h06. Read sends ACK then rdata bytes LSB first, 5 bytes total.
- TX handshake: tx_dv pulses for exactly one cycle, only when tx_active=0. The next byte waits for tx_done, so there is at most one byte in flight. Afterwards the block returns to IDLE.
- Inter-byte timeout: in CMD/ADDR/DATA/CSUM a counter reloads on each rx_dv. On reaching TIMEOUT_CYCLES -> IDLE silently, err_count+1.
- Overrun: an rx_dv arriving in EXEC/RESP is dropped, err_count+1, and does not affect the response.
- Simultaneous events: an rx_dv in the same cycle as a timeout expiry is processed and the timeout is discarded. err_count saturates at 8'hFF.
- Latency: the first tx_dv of the response occurs at most 2 cycles after mem_ready for a good frame, or after the CSUM rx_dv for NAK, given tx_active=0.

Decomposition:
- Package uart_cmd_pkg: state enum, SYNC/ACK(8'h06)/NAK(8'h15)/CMD_W/CMD_R constants, frame length constants.
- One natural sub-module, uart_resp_sequencer: a byte queue of up to 5 entries that drives the tx_dv/tx_done handshake. The parser FSM stays in the top module.

Test Plan:
- Write frame A5 57 00 01 00 00 EF BE AD DE 74 -> one mem_we with mem_addr=32'h00000100 and mem_wdata=32'hDEADBEEF held until mem_ready. Then tx bytes 06; err_count=0.
- Read frame A5 52 00 01 00 00 53, with mem_rdata=32'h12345678 -> one mem_re, then tx bytes 06 78 56 34 12 in order, each tx_dv issued after the previous tx_done.
- Same write frame with CSUM 75 -> no mem_we, tx 15, err_count=1. A following valid frame is executed normally.
- Unknown CMD: A5 41 -> immediate tx 15, err_count+1, back in IDLE.
- A5 57 00, then silence for TIMEOUT_CYCLES+2 -> IDLE, no bus access, no tx, err_count+1. A valid write afterward -> ACK.
- Bus stall: hold mem_ready=0 for MEM_TIMEOUT_CYCLES -> request dropped, tx 15. Separately, pulse resetn=0 between ACK and the rdata bytes of a read -> all outputs zero, no further tx_dv, busy=0.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the debug-UART command responder.
// Frame layout: SYNC, CMD, ADDR[4] LSB first, DATA[4] LSB first (writes only), CSUM.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CSUM,
        ST_EXEC,
        ST_RESP
    } state_t;

    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;
    localparam logic [7:0] CMD_W    = 8'h57;
    localparam logic [7:0] CMD_R    = 8'h52;

    localparam int ADDR_BYTES     = 4;
    localparam int DATA_BYTES     = 4;
    localparam int RESP_MAX_BYTES = 5;
    localparam int RESP_W         = 8 * RESP_MAX_BYTES;

    localparam logic [1:0] ADDR_LAST_IDX = 2'(ADDR_BYTES - 1);
    localparam logic [1:0] DATA_LAST_IDX = 2'(DATA_BYTES - 1);

    // Adds up to three events to an 8-bit counter, pinning it at 8'hFF.
    function automatic logic [7:0] satAdd(input logic [7:0] value, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, value} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/uart_resp_sequencer.sv
// Holds up to five response bytes and feeds them to uart_tx one at a time,
// waiting for tx_done between bytes so only one byte is ever in flight.
module uart_resp_sequencer
    import uart_cmd_pkg::*;
(
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              load_i,
    input  logic [2:0]        loadCount_i,
    input  logic [RESP_W-1:0] loadBytes_i,
    input  logic              txActive_i,
    input  logic              txDone_i,
    output logic              txDv_o,
    output logic [7:0]        txByte_o,
    output logic              busy_o
);

    logic [RESP_W-1:0] queue_q;
    logic [2:0]        count_q;
    logic              inFlight_q;
    logic              txDv_q;
    logic [7:0]        txByte_q;

    // The first byte may launch straight from the load to keep response latency short.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            queue_q    <= '0;
            count_q    <= '0;
            inFlight_q <= 1'b0;
            txDv_q     <= 1'b0;
            txByte_q   <= '0;
        end else begin
            txDv_q <= 1'b0;
            if (load_i) begin
                if (!txActive_i && loadCount_i != 3'd0) begin
                    txDv_q     <= 1'b1;
                    txByte_q   <= loadBytes_i[7:0];
                    queue_q    <= {8'h00, loadBytes_i[RESP_W-1:8]};
                    count_q    <= loadCount_i - 3'd1;
                    inFlight_q <= 1'b1;
                end else begin
                    queue_q    <= loadBytes_i;
                    count_q    <= loadCount_i;
                    inFlight_q <= 1'b0;
                end
            end else if (inFlight_q) begin
                if (txDone_i) begin
                    inFlight_q <= 1'b0;
                end
            end else if (count_q != 3'd0 && !txActive_i) begin
                txDv_q     <= 1'b1;
                txByte_q   <= queue_q[7:0];
                queue_q    <= {8'h00, queue_q[RESP_W-1:8]};
                count_q    <= count_q - 3'd1;
                inFlight_q <= 1'b1;
            end
        end
    end

    assign txDv_o   = txDv_q;
    assign txByte_o = txByte_q;
    assign busy_o   = load_i || (count_q != 3'd0) || inFlight_q;

endmodule

// File: rtl/uart_cmd_responder.sv
// Parses framed debug-UART commands, runs one 32-bit bus read or write per frame
// and answers with ACK (plus read data) or NAK through the response sequencer.
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE          = 8'hA5,
    parameter int         TIMEOUT_CYCLES     = 2_000_000,
    parameter int         MEM_TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    output logic        tx_dv,
    output logic [7:0]  tx_byte,
    input  logic        tx_active,
    input  logic        tx_done,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic [7:0]  err_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int MW = $clog2(MEM_TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [MW-1:0] MEM_LAST = MW'(MEM_TIMEOUT_CYCLES - 1);

    state_t            state_q;
    logic [1:0]        byteIdx_q;
    logic              isWrite_q;
    logic [7:0]        csum_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              memWe_q;
    logic              memRe_q;
    logic [TW-1:0]     tmoCnt_q;
    logic [MW-1:0]     memCnt_q;
    logic              respLoad_q;
    logic [2:0]        respCount_q;
    logic [RESP_W-1:0] respBytes_q;
    logic [7:0]        errCount_q;
    logic [7:0]        errCount_d;

    logic inFrame;
    logic tmoExpire;
    logic cmdBad;
    logic csumBad;
    logic memExpire;
    logic overrun;
    logic frameErr;
    logic seqBusy;

    // An overrun can coincide with a bus timeout, so up to two errors land in one cycle.
    always_comb begin
        inFrame    = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                     (state_q == ST_DATA) || (state_q == ST_CSUM);
        tmoExpire  = inFrame && !rx_dv && (tmoCnt_q == TMO_LAST);
        cmdBad     = (state_q == ST_CMD) && rx_dv && (rx_byte != CMD_W) && (rx_byte != CMD_R);
        csumBad    = (state_q == ST_CSUM) && rx_dv && (rx_byte != csum_q);
        memExpire  = (state_q == ST_EXEC) && !mem_ready && (memCnt_q == MEM_LAST);
        overrun    = ((state_q == ST_EXEC) || (state_q == ST_RESP)) && rx_dv;
        frameErr   = tmoExpire || cmdBad || csumBad || memExpire;
        errCount_d = satAdd(errCount_q, {1'b0, frameErr} + {1'b0, overrun});
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            byteIdx_q   <= '0;
            isWrite_q   <= 1'b0;
            csum_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            memWe_q     <= 1'b0;
            memRe_q     <= 1'b0;
            tmoCnt_q    <= '0;
            memCnt_q    <= '0;
            respLoad_q  <= 1'b0;
            respCount_q <= '0;
            respBytes_q <= '0;
            errCount_q  <= '0;
        end else begin
            respLoad_q <= 1'b0;
            errCount_q <= errCount_d;
            case (state_q)
                ST_IDLE: begin
                    if (rx_dv && rx_byte == SYNC_BYTE) begin
                        state_q  <= ST_CMD;
                        tmoCnt_q <= '0;
                        csum_q   <= '0;
                    end
                end
                ST_CMD, ST_ADDR, ST_DATA, ST_CSUM: begin
                    if (rx_dv) begin
                        tmoCnt_q <= '0;
                        csum_q   <= csum_q ^ rx_byte;
                        case (state_q)
                            ST_CMD: begin
                                if (cmdBad) begin
                                    respBytes_q <= {32'h0, NAK_BYTE};
                                    respCount_q <= 3'd1;
                                    respLoad_q  <= 1'b1;
                                    state_q     <= ST_RESP;
                                end else begin
                                    isWrite_q <= (rx_byte == CMD_W);
                                    byteIdx_q <= '0;
                                    state_q   <= ST_ADDR;
                                end
                            end
                            ST_ADDR: begin
                                addr_q[{byteIdx_q, 3'b000} +: 8] <= rx_byte;
                                byteIdx_q <= byteIdx_q + 2'd1;
                                if (byteIdx_q == ADDR_LAST_IDX) begin
                                    state_q <= isWrite_q ? ST_DATA : ST_CSUM;
                                end
                            end
                            ST_DATA: begin
                                wdata_q[{byteIdx_q, 3'b000} +: 8] <= rx_byte;
                                byteIdx_q <= byteIdx_q + 2'd1;
                                if (byteIdx_q == DATA_LAST_IDX) begin
                                    state_q <= ST_CSUM;
                                end
                            end
                            default: begin
                                if (csumBad) begin
                                    respBytes_q <= {32'h0, NAK_BYTE};
                                    respCount_q <= 3'd1;
                                    respLoad_q  <= 1'b1;
                                    state_q     <= ST_RESP;
                                end else begin
                                    memWe_q  <= isWrite_q;
                                    memRe_q  <= !isWrite_q;
                                    memCnt_q <= '0;
                                    state_q  <= ST_EXEC;
                                end
                            end
                        endcase
                    end else if (tmoExpire) begin
                        state_q <= ST_IDLE;
                    end else begin
                        tmoCnt_q <= tmoCnt_q + TW'(1);
                    end
                end
                ST_EXEC: begin
                    if (mem_ready) begin
                        memWe_q     <= 1'b0;
                        memRe_q     <= 1'b0;
                        respBytes_q <= isWrite_q ? {32'h0, ACK_BYTE} : {mem_rdata, ACK_BYTE};
                        respCount_q <= isWrite_q ? 3'd1 : 3'd5;
                        respLoad_q  <= 1'b1;
                        state_q     <= ST_RESP;
                    end else if (memExpire) begin
                        memWe_q     <= 1'b0;
                        memRe_q     <= 1'b0;
                        respBytes_q <= {32'h0, NAK_BYTE};
                        respCount_q <= 3'd1;
                        respLoad_q  <= 1'b1;
                        state_q     <= ST_RESP;
                    end else begin
                        memCnt_q <= memCnt_q + MW'(1);
                    end
                end
                ST_RESP: begin
                    if (!seqBusy) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    uart_resp_sequencer uSeq (
        .clk_i       (clk),
        .resetn_i    (resetn),
        .load_i      (respLoad_q),
        .loadCount_i (respCount_q),
        .loadBytes_i (respBytes_q),
        .txActive_i  (tx_active),
        .txDone_i    (tx_done),
        .txDv_o      (tx_dv),
        .txByte_o    (tx_byte),
        .busy_o      (seqBusy)
    );

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = memWe_q;
    assign mem_re    = memRe_q;
    assign busy      = (state_q != ST_IDLE);
    assign err_count = errCount_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder with a uart_tx stand-in and a simple bus slave.
module tb_uart_cmd_responder;

    localparam int TMO     = 400;
    localparam int MEM_TMO = 1024;
    localparam int TX_LEN  = 20;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active = 1'b0;
    logic        tx_done = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;
    logic        busy;
    logic [7:0]  err_count;

    uart_cmd_responder #(
        .SYNC_BYTE          (8'hA5),
        .TIMEOUT_CYCLES     (TMO),
        .MEM_TIMEOUT_CYCLES (MEM_TMO)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rx_dv     (rx_dv),
        .rx_byte   (rx_byte),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int txBusy = 0;
    logic [7:0] txLog[$];
    int txCyc[$];
    int txViol = 0;
    bit outstanding = 1'b0;
    logic [7:0] curTx = 8'h00;
    int memWait = 2;
    bit memStall = 1'b0;
    int memCnt = 0;
    int weStarts = 0;
    int reStarts = 0;
    int holdErr = 0;
    int weHigh = 0;
    int readyCyc = 0;
    logic [31:0] seenAddr = 32'h0;
    logic [31:0] seenWdata = 32'h0;
    logic [7:0] frameQ[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for uart_tx: goes active the cycle after tx_dv, pulses tx_done TX_LEN cycles later.
    always @(posedge clk) begin
        if (!resetn) begin
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
            txBusy    <= 0;
        end else begin
            tx_done <= 1'b0;
            if (tx_dv) begin
                tx_active <= 1'b1;
                txBusy    <= TX_LEN;
            end else if (txBusy > 1) begin
                txBusy <= txBusy - 1;
            end else if (txBusy == 1) begin
                txBusy    <= 0;
                tx_active <= 1'b0;
                tx_done   <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            memCnt = 0;
        end else begin
            mem_ready <= 1'b0;
            if ((mem_we || mem_re) && !mem_ready) begin
                if (memCnt == 0) begin
                    if (mem_we) weStarts++;
                    if (mem_re) reStarts++;
                    seenAddr  = mem_addr;
                    seenWdata = mem_wdata;
                end else if (mem_addr !== seenAddr || mem_wdata !== seenWdata) begin
                    holdErr++;
                end
                if (!memStall && memCnt >= memWait) begin
                    mem_ready <= 1'b1;
                    memCnt = 0;
                end else begin
                    memCnt++;
                end
            end else if (!(mem_we || mem_re)) begin
                memCnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!resetn) begin
            outstanding = 1'b0;
        end else begin
            if (mem_we) weHigh++;
            if (mem_ready) readyCyc = cyc;
            if (tx_done) outstanding = 1'b0;
            if (outstanding && tx_byte !== curTx) txViol++;
            if (tx_dv) begin
                if (tx_active || outstanding) txViol++;
                txLog.push_back(tx_byte);
                txCyc.push_back(cyc);
                curTx = tx_byte;
                outstanding = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearLogs();
        txLog.delete();
        txCyc.delete();
        weStarts = 0;
        reStarts = 0;
        holdErr  = 0;
        weHigh   = 0;
        txViol   = 0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv = 1'b0;
        tick(2);
    endtask

    task automatic sendFrame();
        foreach (frameQ[i]) sendByte(frameQ[i]);
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n;
        n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL %s_idle: busy=%b after %0d cycles, want 0", name, busy, n);
        else passes++;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(3);
        checks++;
        if ({tx_dv, tx_byte, mem_we, mem_re, mem_addr, mem_wdata, busy, err_count} !== '0)
            $display("[TB] FAIL reset_outputs: tx_dv=%b tx_byte=%h we=%b re=%b addr=%h wdata=%h busy=%b err=%h, want all 0",
                     tx_dv, tx_byte, mem_we, mem_re, mem_addr, mem_wdata, busy, err_count);
        else passes++;
        resetn = 1'b1;
        tick(2);
    endtask

    task automatic writeFrame(input logic [7:0] csum);
        frameQ = {8'hA5, 8'h57, 8'h00, 8'h01, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, csum};
    endtask

    task automatic checkSingleTx(input string name, input logic [7:0] expByte);
        checks++;
        if (txLog.size() != 1 || txLog[0] !== expByte)
            $display("[TB] FAIL %s_tx: %0d bytes first=%h, want 1 byte %h", name, txLog.size(), txLog[0], expByte);
        else passes++;
    endtask

    task automatic test_write();
        int lat;
        clearLogs();
        memWait = 3;
        writeFrame(8'h74);
        sendFrame();
        waitIdle("write", 500);
        checks++;
        if (weStarts != 1 || reStarts != 0) $display("[TB] FAIL write_req: we=%0d re=%0d, want 1 0", weStarts, reStarts);
        else passes++;
        checks++;
        if (seenAddr !== 32'h00000100 || seenWdata !== 32'hDEADBEEF || holdErr != 0)
            $display("[TB] FAIL write_bus: addr=%h wdata=%h holdErr=%0d, want 00000100 deadbeef 0", seenAddr, seenWdata, holdErr);
        else passes++;
        checkSingleTx("write", 8'h06);
        lat = (txCyc.size() > 0) ? txCyc[0] - readyCyc : -1;
        checks++;
        if (lat < 1 || lat > 2) $display("[TB] FAIL write_latency: %0d cycles, want 1..2", lat);
        else passes++;
        checks++;
        if (err_count !== 8'd0) $display("[TB] FAIL write_err: %0d, want 0", err_count);
        else passes++;
    endtask

    task automatic test_read();
        logic [39:0] got;
        clearLogs();
        memWait = 2;
        mem_rdata = 32'h12345678;
        frameQ = {8'hA5, 8'h52, 8'h00, 8'h01, 8'h00, 8'h00, 8'h53};
        sendFrame();
        waitIdle("read", 800);
        checks++;
        if (reStarts != 1 || weStarts != 0 || seenAddr !== 32'h00000100)
            $display("[TB] FAIL read_req: re=%0d we=%0d addr=%h, want 1 0 00000100", reStarts, weStarts, seenAddr);
        else passes++;
        got = {txLog[4], txLog[3], txLog[2], txLog[1], txLog[0]};
        checks++;
        if (txLog.size() != 5 || got !== 40'h12345678_06)
            $display("[TB] FAIL read_tx: %0d bytes %h, want 5 bytes 1234567806", txLog.size(), got);
        else passes++;
        checks++;
        if (txViol != 0) $display("[TB] FAIL read_handshake: %0d violations, want 0", txViol);
        else passes++;
        checks++;
        if (err_count !== 8'd0) $display("[TB] FAIL read_err: %0d, want 0", err_count);
        else passes++;
    endtask

    task automatic test_bad_csum();
        clearLogs();
        writeFrame(8'h75);
        sendFrame();
        waitIdle("badcsum", 500);
        checks++;
        if (weStarts != 0 || reStarts != 0 || weHigh != 0)
            $display("[TB] FAIL badcsum_bus: we=%0d re=%0d weHigh=%0d, want 0 0 0", weStarts, reStarts, weHigh);
        else passes++;
        checkSingleTx("badcsum", 8'h15);
        checks++;
        if (err_count !== 8'd1) $display("[TB] FAIL badcsum_err: %0d, want 1", err_count);
        else passes++;
        clearLogs();
        writeFrame(8'h74);
        sendFrame();
        waitIdle("badcsum_next", 500);
        checks++;
        if (weStarts != 1) $display("[TB] FAIL badcsum_next_req: we=%0d, want 1", weStarts);
        else passes++;
        checkSingleTx("badcsum_next", 8'h06);
    endtask

    task automatic test_unknown_cmd();
        clearLogs();
        frameQ = {8'hA5, 8'h41};
        sendFrame();
        waitIdle("unknown", 500);
        checkSingleTx("unknown", 8'h15);
        checks++;
        if (err_count !== 8'd2 || weStarts != 0 || reStarts != 0)
            $display("[TB] FAIL unknown_err: err=%0d we=%0d re=%0d, want 2 0 0", err_count, weStarts, reStarts);
        else passes++;
    endtask

    task automatic test_timeout();
        clearLogs();
        frameQ = {8'hA5, 8'h57, 8'h00};
        sendFrame();
        tick(TMO - 3);
        checks++;
        if (busy !== 1'b1) $display("[TB] FAIL timeout_early: busy=%b one cycle before expiry, want 1", busy);
        else passes++;
        tick(1);
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL timeout_expire: busy=%b at expiry, want 0", busy);
        else passes++;
        tick(2);
        checks++;
        if (err_count !== 8'd3 || weStarts != 0 || txLog.size() != 0)
            $display("[TB] FAIL timeout_effects: err=%0d we=%0d tx=%0d, want 3 0 0", err_count, weStarts, txLog.size());
        else passes++;
        clearLogs();
        writeFrame(8'h74);
        sendFrame();
        waitIdle("timeout_next", 500);
        checkSingleTx("timeout_next", 8'h06);
    endtask

    task automatic test_bus_stall();
        clearLogs();
        memStall = 1'b1;
        writeFrame(8'h74);
        sendFrame();
        waitIdle("stall", 3000);
        memStall = 1'b0;
        checks++;
        if (weStarts != 1 || weHigh != MEM_TMO || mem_we !== 1'b0)
            $display("[TB] FAIL stall_req: starts=%0d held=%0d we=%b, want 1 %0d 0", weStarts, weHigh, mem_we, MEM_TMO);
        else passes++;
        checkSingleTx("stall", 8'h15);
        checks++;
        if (err_count !== 8'd4) $display("[TB] FAIL stall_err: %0d, want 4", err_count);
        else passes++;
    endtask

    task automatic test_overrun();
        logic [39:0] got;
        clearLogs();
        memWait = 30;
        mem_rdata = 32'hCAFEF00D;
        frameQ = {8'hA5, 8'h52, 8'h10, 8'h00, 8'h00, 8'h00, 8'h42};
        sendFrame();
        sendByte(8'hA5);
        waitIdle("overrun", 800);
        got = {txLog[4], txLog[3], txLog[2], txLog[1], txLog[0]};
        checks++;
        if (txLog.size() != 5 || got !== 40'hCAFEF00D_06 || seenAddr !== 32'h00000010)
            $display("[TB] FAIL overrun_tx: %0d bytes %h addr=%h, want 5 bytes cafef00d06 addr 00000010",
                     txLog.size(), got, seenAddr);
        else passes++;
        tick(3);
        checks++;
        if (err_count !== 8'd5 || busy !== 1'b0)
            $display("[TB] FAIL overrun_err: err=%0d busy=%b, want 5 0", err_count, busy);
        else passes++;
        memWait = 2;
    endtask

    task automatic test_saturation();
        frameQ = {8'hA5, 8'h41};
        for (int i = 0; i < 250; i++) begin
            sendFrame();
            waitIdle("sat", 200);
        end
        checks++;
        if (err_count !== 8'hFF) $display("[TB] FAIL sat_reach: %h, want ff", err_count);
        else passes++;
        for (int i = 0; i < 10; i++) begin
            sendFrame();
            waitIdle("sat_hold", 200);
        end
        checks++;
        if (err_count !== 8'hFF) $display("[TB] FAIL sat_hold: %h, want ff", err_count);
        else passes++;
    endtask

    task automatic test_reset_mid_read();
        int n;
        clearLogs();
        memWait = 2;
        mem_rdata = 32'h12345678;
        frameQ = {8'hA5, 8'h52, 8'h00, 8'h01, 8'h00, 8'h00, 8'h53};
        sendFrame();
        n = 0;
        while (txLog.size() < 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (txLog.size() != 1 || txLog[0] !== 8'h06)
            $display("[TB] FAIL rstmid_ack: %0d bytes first=%h, want 1 byte 06", txLog.size(), txLog[0]);
        else passes++;
        tick(5);
        resetn = 1'b0;
        tick(1);
        checks++;
        if ({tx_dv, tx_byte, mem_we, mem_re, mem_addr, mem_wdata, busy, err_count} !== '0)
            $display("[TB] FAIL rstmid_outputs: tx_dv=%b tx_byte=%h we=%b re=%b addr=%h wdata=%h busy=%b err=%h, want all 0",
                     tx_dv, tx_byte, mem_we, mem_re, mem_addr, mem_wdata, busy, err_count);
        else passes++;
        tick(1);
        resetn = 1'b1;
        tick(200);
        checks++;
        if (txLog.size() != 1 || busy !== 1'b0)
            $display("[TB] FAIL rstmid_quiet: %0d bytes busy=%b, want 1 byte busy 0", txLog.size(), busy);
        else passes++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_bad_csum();
        test_unknown_cmd();
        test_timeout();
        test_bus_stall();
        test_overrun();
        test_saturation();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
